// File: rtl/acc_readout.sv
// Drains DEPTH accumulator entries per job, requantizes each one to OUT_WIDTH bits
// (optional ReLU, rounded arithmetic shift, saturation) and streams the results out
// through a 2-entry valid/ready FIFO.
module acc_readout #(
   parameter int DEPTH             = 8,
   parameter int PARTIAL_SUM_WIDTH = 45,
   parameter int OUT_WIDTH         = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [5:0]                          shift,
   input  logic                                relu_en,
   output logic                                Acc_Rd_en,
   output logic [AW-1:0]                       Acc_Rd_Addr,
   input  logic signed [PARTIAL_SUM_WIDTH-1:0] Acc_Rd_Data,
   output logic signed [OUT_WIDTH-1:0]         Out_Data,
   output logic                                Out_Valid,
   input  logic                                Out_Ready,
   output logic                                Out_Last,
   output logic                                Busy,
   output logic                                Done
);

   localparam int PSW = PARTIAL_SUM_WIDTH;
   localparam int CW  = AW + 1;
   localparam logic signed [PSW:0] MAXV = {{(PSW-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PSW:0] MINV = {{(PSW-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state, state_nxt;
   logic [5:0]                  shift_q;
   logic                        relu_q;
   logic [CW-1:0]               rd_cnt;
   logic                        inflight, inflight_last;
   logic signed [OUT_WIDTH-1:0] fifo_d [2];
   logic [1:0]                  fifo_l;
   logic                        wr_ptr, rd_ptr;
   logic [1:0]                  count;
   logic                        accept, pop;
   logic [2:0]                  occ;

   // Rounding add is done one bit wider than the entry so the positive maximum cannot wrap.
   function automatic logic signed [OUT_WIDTH-1:0] requant(
      input logic signed [PSW-1:0] x_in,
      input logic [5:0]            sh,
      input logic                  relu
   );
      logic signed [PSW:0] x, rnd, y;
      x   = {x_in[PSW-1], x_in};
      rnd = '0;
      if (relu && x_in[PSW-1]) x = '0;
      if (sh == 6'd0) begin
         y = x;
      end else if (32'(sh) >= PSW) begin
         y = x[PSW] ? '1 : '0;
      end else begin
         rnd = (PSW+1)'(1) << (sh - 6'd1);
         y   = (x + rnd) >>> sh;
      end
      if (y > MAXV)      return MAXV[OUT_WIDTH-1:0];
      else if (y < MINV) return MINV[OUT_WIDTH-1:0];
      else               return y[OUT_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         shift_q       <= '0;
         relu_q        <= 1'b0;
         rd_cnt        <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         fifo_d[0]     <= '0;
         fifo_d[1]     <= '0;
         fifo_l        <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         count         <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            shift_q <= shift;
            relu_q  <= relu_en;
         end
         if (state == DONE)  rd_cnt <= '0;
         else if (Acc_Rd_en) rd_cnt <= rd_cnt + 1'b1;
         inflight      <= Acc_Rd_en;
         inflight_last <= Acc_Rd_en && (rd_cnt == CW'(DEPTH-1));
         if (inflight) begin
            fifo_d[wr_ptr] <= requant(Acc_Rd_Data, shift_q, relu_q);
            fifo_l[wr_ptr] <= inflight_last;
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   // The first read is issued in the accepting cycle so data lands in the FIFO one cycle later.
   always_comb begin
      state_nxt   = state;
      accept      = (state == IDLE) && start;
      Out_Valid   = (count != 2'd0);
      pop         = Out_Valid && Out_Ready;
      Out_Data    = Out_Valid ? fifo_d[rd_ptr] : '0;
      Out_Last    = Out_Valid && fifo_l[rd_ptr];
      occ         = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
      Acc_Rd_en   = !rst && (accept || (state == RUN)) && (rd_cnt < CW'(DEPTH)) && (occ < 3'd2);
      Acc_Rd_Addr = Acc_Rd_en ? rd_cnt[AW-1:0] : '0;
      Busy        = (state != IDLE);
      Done        = (state == DONE);
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (pop && Out_Last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_acc_readout.sv
// Bench for acc_readout: table of requantization jobs, scoreboard queue of expected
// outputs, plus stall, restart-ignore and mid-job reset sequences.
module tb_acc_readout;

   localparam int DEPTH = 8;
   localparam int PSW   = 45;
   localparam int OW    = 8;
   localparam longint P43  = 64'sd1 <<< 43;
   localparam longint P44  = 64'sd1 <<< 44;
   localparam longint MAXP = P44 - 1;

   logic                  clk = 1'b0;
   logic                  rst, start, relu_en, Out_Ready;
   logic [5:0]            shift;
   logic                  Acc_Rd_en;
   logic [2:0]            Acc_Rd_Addr;
   logic signed [PSW-1:0] Acc_Rd_Data = '0;
   logic signed [OW-1:0]  Out_Data;
   logic                  Out_Valid, Out_Last, Busy, Done;

   typedef struct packed {
      logic [5:0] sh;
      logic       relu;
      longint     x;
      int         y;
   } vec_t;

   typedef struct packed {
      int   d;
      logic last;
   } exp_t;

   vec_t   tbl[$];
   exp_t   q[$];
   exp_t   mon_e;
   longint xs[DEPTH];
   int     ys[DEPTH];
   logic signed [PSW-1:0] mem [DEPTH];

   int n_vec = 0, n_err = 0;
   int n_xfer = 0, n_done = 0;
   int cyc = 0, last_cyc = -10, exp_addr = 0;
   logic stall_hold = 1'b0, held_l = 1'b0;
   logic signed [OW-1:0] held_d = '0;

   always #5 clk = ~clk;

   acc_readout #(.DEPTH(DEPTH), .PARTIAL_SUM_WIDTH(PSW), .OUT_WIDTH(OW)) dut (
      .clk(clk), .rst(rst), .start(start), .shift(shift), .relu_en(relu_en),
      .Acc_Rd_en(Acc_Rd_en), .Acc_Rd_Addr(Acc_Rd_Addr), .Acc_Rd_Data(Acc_Rd_Data),
      .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Last(Out_Last), .Busy(Busy), .Done(Done)
   );

   function automatic void check(input string name, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Accumulator memory model: one-cycle read latency, junk when no read was issued.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      Acc_Rd_Data <= Acc_Rd_en ? mem[Acc_Rd_Addr] : 45'sd77;
   end

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         exp_addr   = 0;
         stall_hold = 1'b0;
      end else begin
         if (Acc_Rd_en) begin
            check("rd_addr", Acc_Rd_Addr, exp_addr);
            exp_addr++;
         end else begin
            check("addr_idle", Acc_Rd_Addr, 0);
         end
         if (stall_hold) begin
            check("stall_valid", Out_Valid, 1);
            check("stall_data", Out_Data, held_d);
            check("stall_last", Out_Last, held_l);
         end
         if (Out_Valid && Out_Ready) begin
            if (q.size() == 0) begin
               check("unexpected_xfer", Out_Data, -999);
            end else begin
               mon_e = q.pop_front();
               check("out_data", Out_Data, mon_e.d);
               check("out_last", Out_Last, mon_e.last);
            end
            n_xfer++;
            if (Out_Last) last_cyc = cyc;
         end
         stall_hold = Out_Valid && !Out_Ready;
         held_d     = Out_Data;
         held_l     = Out_Last;
         if (Done) begin
            n_done++;
            check("done_latency", cyc, last_cyc + 1);
            exp_addr = 0;
         end
      end
   end

   task automatic chk_zero(input string tag);
      check({tag, "_rd_en"}, Acc_Rd_en, 0);
      check({tag, "_rd_addr"}, Acc_Rd_Addr, 0);
      check({tag, "_data"}, Out_Data, 0);
      check({tag, "_valid"}, Out_Valid, 0);
      check({tag, "_last"}, Out_Last, 0);
      check({tag, "_busy"}, Busy, 0);
      check({tag, "_done"}, Done, 0);
   endtask

   task automatic add_job(input logic [5:0] sh, input logic relu);
      for (int i = 0; i < DEPTH; i++) tbl.push_back('{sh: sh, relu: relu, x: xs[i], y: ys[i]});
   endtask

   // mode 0: Out_Ready high, 1: Out_Ready 1,0,0,1 pattern, 2: start re-pulsed after 3rd
   // transfer, 3: reset after 4th transfer.
   task automatic run_job(input int j, input int mode);
      int  base_x, base_d, k;
      bit  did_rst;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = tbl[j*DEPTH+i].x[PSW-1:0];
         q.push_back('{d: tbl[j*DEPTH+i].y, last: (i == DEPTH-1)});
      end
      base_x  = n_xfer;
      base_d  = n_done;
      did_rst = 1'b0;
      @(posedge clk); #1;
      start     = 1'b1;
      shift     = tbl[j*DEPTH].sh;
      relu_en   = tbl[j*DEPTH].relu;
      Out_Ready = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      shift   = 6'h2a;
      relu_en = ~relu_en;
      check("busy_after_start", Busy, 1);
      check("valid_start_plus1", Out_Valid, 0);
      @(posedge clk); #1;
      check("valid_start_plus2", Out_Valid, 1);
      k = 0;
      while (!Done && k < 200) begin
         if (mode == 1) Out_Ready = (k % 4 == 0) || (k % 4 == 3);
         start = (mode == 2) && (n_xfer - base_x == 3);
         if (mode == 3 && n_xfer - base_x == 4) begin
            rst = 1'b1;
            #1 chk_zero("rst_mid");
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            chk_zero("rst_hold");
            repeat (2) @(posedge clk);
            #1 chk_zero("rst_release");
            did_rst = 1'b1;
            break;
         end
         @(posedge clk); #1;
         k++;
      end
      start     = 1'b0;
      Out_Ready = 1'b1;
      if (mode == 3) begin
         check("rst_reached", did_rst, 1);
         check("rst_sb_flushed", q.size(), 0);
      end else begin
         check("done_in_time", k < 200, 1);
         repeat (3) @(posedge clk);
         #1;
         check("xfer_count", n_xfer - base_x, DEPTH);
         check("done_count", n_done - base_d, 1);
         check("sb_empty", q.size(), 0);
         check("idle_after", Busy, 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; shift = '0; relu_en = 1'b0; Out_Ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;

      xs = '{100, -100, 255, 256, -129, 0, 1000, -1000};
      ys = '{100, -100, 127, 127, -128, 0, 127, -128};           add_job(6'd0, 1'b0);
      xs = '{3, 5, -3, -5, 6, 7, -6, -7};
      ys = '{2, 3, -1, -2, 3, 4, -3, -3};                        add_job(6'd1, 1'b0);
      ys = '{2, 3, 0, 0, 3, 4, 0, 0};                            add_job(6'd1, 1'b1);
      xs = '{MAXP, -P44, P43, P43-1, -P43, -P43-1, 0, 1};
      ys = '{1, -1, 1, 0, 0, -1, 0, 0};                          add_job(6'd44, 1'b0);
      xs = '{5, -5, MAXP, -P44, 0, -1, 127, -128};
      ys = '{0, -1, 0, -1, 0, -1, 0, -1};                        add_job(6'd45, 1'b0);
      xs = '{2040, 2023, 24, 23, -500, 8, 7, MAXP};
      ys = '{127, 126, 2, 1, 0, 1, 0, 127};                      add_job(6'd4, 1'b1);
      xs = '{-1024, -1032, -1028, -1019, 1019, 1020, -4, -5};
      ys = '{-128, -128, -128, -127, 127, 127, 0, -1};           add_job(6'd3, 1'b0);

      #1 chk_zero("rst_assert");
      repeat (3) @(posedge clk);
      #1 chk_zero("rst_held");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_zero("post_rst");

      for (int j = 0; j < tbl.size() / DEPTH; j++) run_job(j, 0);
      run_job(1, 1);
      run_job(0, 2);
      run_job(2, 3);
      run_job(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/acc_readout.md
ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of accumulator entries drained per job.
REQ-002 SHALL have parameter PARTIAL_SUM_WIDTH, default 45, signed accumulator entry width.
REQ-003 SHALL have parameter OUT_WIDTH, default 8, signed output activation width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-007 shift  input  6  right-shift amount for requantization; latched on accepted start.
REQ-008 relu_en  input  1  1 = clamp negative entries to zero; latched on accepted start.
REQ-009 Acc_Rd_en  output  1  accumulator read strobe.
REQ-010 Acc_Rd_Addr  output  3  accumulator read address.
REQ-011 Acc_Rd_Data  input  PARTIAL_SUM_WIDTH  signed read data, valid exactly one cycle after Acc_Rd_en.
REQ-012 Out_Data  output  OUT_WIDTH  signed requantized activation.
REQ-013 Out_Valid  output  1  Out_Data valid.
REQ-014 Out_Ready  input  1  downstream accepts; transfer when Out_Valid and Out_Ready both high.
REQ-015 Out_Last  output  1  high with Out_Valid for the entry read from address DEPTH-1.
REQ-016 Busy  output  1  high from accepted start until Done.
REQ-017 Done  output  1  one-cycle pulse after final transfer.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the cycle the Out_Last transfer occurs; DONE->IDLE unconditionally next cycle.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 In RUN, reads SHALL be issued at addresses 0,1,...,DEPTH-1 in order, one address per Acc_Rd_en pulse, never repeated or skipped.
REQ-021 A 2-entry output FIFO SHALL buffer returned data; Acc_Rd_en SHALL assert only when (FIFO occupancy + reads in flight) < 2 counted after this cycle's output transfer.
REQ-022 With Out_Ready held high, read issue SHALL be one per cycle, first Out_Valid 2 cycles after the start cycle, DEPTH consecutive transfers.
REQ-023 Out_Data and Out_Last SHALL hold stable while Out_Valid high and Out_Ready low; Out_Valid SHALL not deassert without a transfer.
REQ-024 Requantization per entry x: if relu_en and x<0, x=0; if shift>0, x = (x + 2^(shift-1)) >>> shift (arithmetic); else unchanged; then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-025 Rounding add SHALL be computed at PARTIAL_SUM_WIDTH+1 bits so no overflow occurs at the positive maximum.
REQ-026 shift >= PARTIAL_SUM_WIDTH SHALL yield 0 for non-negative x and -1 for negative x before saturation.
REQ-027 Requantization SHALL be applied at FIFO write; FIFO holds OUT_WIDTH-bit values plus last flag.
REQ-028 Done SHALL pulse in the DONE state; Busy SHALL be low in IDLE only.
REQ-029 Acc_Rd_Addr SHALL be 0 whenever Acc_Rd_en is low.

Reset
REQ-030 rst high SHALL immediately force IDLE, empty FIFO, clear in-flight tracking and read address counter.
REQ-031 During and after reset: Acc_Rd_en=0, Acc_Rd_Addr=0, Out_Data=0, Out_Valid=0, Out_Last=0, Busy=0, Done=0; latched shift=0, relu_en=0.
REQ-032 Reset mid-job SHALL discard the job; read data arriving the cycle after reset release SHALL be ignored.

Verification
REQ-033 Acc entries {0..7}={100,-100,255,256,-129,0,1000,-1000}, shift=0, relu_en=0, Out_Ready=1 -> outputs 100,-100,127,127,-128,0,127,-128; Out_Last on 8th; Done 1 cycle after.
REQ-034 Entries {3,5,-3,-5,6,7,-6,-7}, shift=1, relu_en=0 -> 2,3,-1,-2,3,4,-3,-3.
REQ-035 Same entries, shift=1, relu_en=1 -> 2,3,0,0,3,4,0,0.
REQ-036 Out_Ready toggled 1,0,0,1 repeating -> same 8 values in order, no drop/duplicate, Out_Data stable while stalled, Acc_Rd_Addr never repeats.
REQ-037 start pulsed again at 3rd transfer -> ignored; exactly 8 transfers, one Done.
REQ-038 rst asserted after 4th transfer -> all outputs 0 same cycle; new start after release -> full 8-entry drain from address 0.
